// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two memory requesters (CPU MEM stage, DMA/loader),
// the arbiter, and the single-port data memory.
// The arbiter connects through the slave modport; the surroundings (pipeline,
// DMA engine and Data_Memory, or a testbench standing in for them) use master.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    // CPU MEM-stage port
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_done;
    logic              cpu_stall;

    // DMA / program-loader port
    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_done;

    // Data memory side
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_rdata;

    // Status
    logic              busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_done, cpu_stall,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_rdata, dma_done,
        output mem_addr, mem_wdata, mem_read, mem_write,
        input  mem_rdata,
        output busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_done, cpu_stall,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_rdata, dma_done,
        input  mem_addr, mem_wdata, mem_read, mem_write,
        output mem_rdata,
        input  busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: serialises CPU (MEM stage) and DMA accesses onto one
// single-port memory with a fixed MEM_LAT-cycle strobe window, pulses a
// one-cycle done to the owner, and stalls the pipeline while a CPU access is
// outstanding. DMA normally yields to the CPU but is forced through after
// STARVE_MAX consecutive losses.
module dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);

    // Latency counter only has to hold MEM_LAT-1 down to 0.
    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    localparam logic [LAT_W-1:0] LAT_LOAD   = LAT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] STARVE_TOP = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              state_reg,      state_next;
    logic                owner_dma_reg,  owner_dma_next;
    logic                we_reg,         we_next;
    logic [ADDR_W-1:0]   addr_reg,       addr_next;
    logic [DATA_W-1:0]   wdata_reg,      wdata_next;
    logic [LAT_W-1:0]    lat_cnt_reg,    lat_cnt_next;
    logic [CNT_W-1:0]    starve_cnt_reg, starve_cnt_next;
    logic [DATA_W-1:0]   cpu_rdata_reg,  cpu_rdata_next;
    logic [DATA_W-1:0]   dma_rdata_reg,  dma_rdata_next;

    logic grant_dma;
    logic grant_cpu;
    logic in_access;
    logic cpu_done;
    logic dma_done;

    // Arbitration decision, only acted on in IDLE. DMA wins when the CPU is
    // quiet or when it has already lost STARVE_MAX times in a row.
    always_comb begin
        grant_dma = bus.dma_req & (~bus.cpu_req | (starve_cnt_reg == STARVE_TOP));
        grant_cpu = bus.cpu_req & ~grant_dma;
    end

    // Next-state and datapath-latch logic for the IDLE -> ACCESS -> RESP walk.
    always_comb begin
        state_next      = state_reg;
        owner_dma_next  = owner_dma_reg;
        we_next         = we_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        lat_cnt_next    = lat_cnt_reg;
        starve_cnt_next = starve_cnt_reg;
        cpu_rdata_next  = cpu_rdata_reg;
        dma_rdata_next  = dma_rdata_reg;

        unique case (state_reg)
            IDLE: begin
                if (grant_dma) begin
                    owner_dma_next  = 1'b1;
                    we_next         = bus.dma_we;
                    addr_next       = bus.dma_addr;
                    wdata_next      = bus.dma_wdata;
                    lat_cnt_next    = LAT_LOAD;
                    starve_cnt_next = '0;
                    state_next      = ACCESS;
                end else if (grant_cpu) begin
                    owner_dma_next  = 1'b0;
                    we_next         = bus.cpu_we;
                    addr_next       = bus.cpu_addr;
                    wdata_next      = bus.cpu_wdata;
                    lat_cnt_next    = LAT_LOAD;
                    // Only a real contention loss counts towards starvation.
                    if (bus.dma_req && (starve_cnt_reg != STARVE_TOP)) begin
                        starve_cnt_next = starve_cnt_reg + CNT_W'(1);
                    end
                    state_next      = ACCESS;
                end
            end

            ACCESS: begin
                if (lat_cnt_reg == '0) begin
                    // Last strobe cycle: the memory output is valid now.
                    if (!we_reg) begin
                        if (owner_dma_reg) begin
                            dma_rdata_next = bus.mem_rdata;
                        end else begin
                            cpu_rdata_next = bus.mem_rdata;
                        end
                    end
                    state_next = RESP;
                end else begin
                    lat_cnt_next = lat_cnt_reg - LAT_W'(1);
                end
            end

            RESP: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset can land mid-access and simply
    // abandons it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            owner_dma_reg  <= 1'b0;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            lat_cnt_reg    <= '0;
            starve_cnt_reg <= '0;
            cpu_rdata_reg  <= '0;
            dma_rdata_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            owner_dma_reg  <= owner_dma_next;
            we_reg         <= we_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            lat_cnt_reg    <= lat_cnt_next;
            starve_cnt_reg <= starve_cnt_next;
            cpu_rdata_reg  <= cpu_rdata_next;
            dma_rdata_reg  <= dma_rdata_next;
        end
    end

    // Output decode: strobes only while in ACCESS, done only in RESP.
    always_comb begin
        in_access = (state_reg == ACCESS);
        cpu_done  = (state_reg == RESP) & ~owner_dma_reg;
        dma_done  = (state_reg == RESP) &  owner_dma_reg;
    end

    assign bus.mem_addr  = addr_reg;
    assign bus.mem_wdata = wdata_reg;
    assign bus.mem_read  = in_access & ~we_reg;
    assign bus.mem_write = in_access &  we_reg;

    assign bus.cpu_rdata = cpu_rdata_reg;
    assign bus.cpu_done  = cpu_done;
    assign bus.dma_rdata = dma_rdata_reg;
    assign bus.dma_done  = dma_done;

    // Stall is combinational so it covers the very cycle the request rises,
    // including while DMA owns the memory.
    assign bus.cpu_stall = bus.cpu_req & ~cpu_done;
    assign bus.busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios followed by randomized
// CPU/DMA traffic, all checked cycle by cycle against a transaction timeline
// model (arbitration points, done times, reference memory contents).
module tb_dmem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LAT  = 2;
    localparam int SMAX = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dmem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Behavioural data memory: combinational read, write on the clock edge.
    logic [31:0] mem     [16];
    logic [31:0] ref_mem [16];

    assign bus.mem_rdata = mem[bus.mem_addr[5:2]];

    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_addr[5:2]] <= bus.mem_wdata;
    end

    int vectors = 0;
    int errors  = 0;

    // Timeline model of the arbiter.
    int          t;
    int          start_t;
    int          done_at;
    int          free_at;
    int          starve;
    bit          own_d;
    bit          own_we;
    logic [31:0] own_addr;
    logic [31:0] own_wdata;
    logic [31:0] pend;
    logic [31:0] exp_crd;
    logic [31:0] exp_drd;
    bit          exp_cdone;
    bit          exp_ddone;
    logic        obs_cdone;
    logic        obs_ddone;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp_v, t);
        end
    endtask

    task automatic model_reset();
        start_t = -100;
        done_at = -100;
        free_at = t;
        starve  = 0;
        own_d   = 1'b0;
        own_we  = 1'b0;
        exp_crd = '0;
        exp_drd = '0;
    endtask

    // Apply the arbitration rule when the memory is free and anyone asks.
    task automatic model_arb();
        if (t >= free_at && (bus.cpu_req || bus.dma_req)) begin
            own_d = bus.dma_req && (!bus.cpu_req || starve == SMAX);
            if (own_d) starve = 0;
            else if (bus.dma_req && starve < SMAX) starve++;
            own_we    = own_d ? bus.dma_we    : bus.cpu_we;
            own_addr  = own_d ? bus.dma_addr  : bus.cpu_addr;
            own_wdata = own_d ? bus.dma_wdata : bus.cpu_wdata;
            start_t   = t;
            done_at   = t + LAT + 1;
            free_at   = t + LAT + 2;
            if (own_we) ref_mem[own_addr[5:2]] = own_wdata;
            else        pend = ref_mem[own_addr[5:2]];
        end
        if (t == done_at && !own_we) begin
            if (own_d) exp_drd = pend;
            else       exp_crd = pend;
        end
    endtask

    task automatic check_outputs();
        bit strobe;
        strobe    = (t > start_t) && (t <= start_t + LAT);
        exp_cdone = (t == done_at) && !own_d;
        exp_ddone = (t == done_at) &&  own_d;
        obs_cdone = bus.cpu_done;
        obs_ddone = bus.dma_done;
        chk("cpu_done",  bus.cpu_done,  exp_cdone);
        chk("dma_done",  bus.dma_done,  exp_ddone);
        chk("cpu_stall", bus.cpu_stall, bus.cpu_req && !exp_cdone);
        chk("busy",      bus.busy,      (t > start_t) && (t < free_at));
        chk("mem_read",  bus.mem_read,  strobe && !own_we);
        chk("mem_write", bus.mem_write, strobe &&  own_we);
        if (strobe) chk("mem_addr", bus.mem_addr, own_addr);
        if (strobe && own_we) chk("mem_wdata", bus.mem_wdata, own_wdata);
        chk("cpu_rdata", bus.cpu_rdata, exp_crd);
        chk("dma_rdata", bus.dma_rdata, exp_drd);
        $display("cyc %0d creq=%0b dreq=%0b rd=%0b wr=%0b addr=%h cdone=%0b ddone=%0b crd=%h drd=%h",
                 t, bus.cpu_req, bus.dma_req, bus.mem_read, bus.mem_write, bus.mem_addr,
                 bus.cpu_done, bus.dma_done, bus.cpu_rdata, bus.dma_rdata);
    endtask

    // One clock cycle: called just after the rising edge with inputs set.
    task automatic cycle();
        model_arb();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        #1;
        t++;
    endtask

    // Single CPU access with nothing else in flight; checks the latency.
    task automatic cpu_access(input bit we, input logic [31:0] addr, input logic [31:0] wd);
        int n;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wd;
        n = 0;
        for (int k = 0; k < 50; k++) begin
            cycle();
            if (obs_cdone === 1'b1) break;
            n++;
        end
        chk("cpu_access_done", obs_cdone, 1'b1);
        chk("cpu_access_latency", n, LAT + 1);
        bus.cpu_req = 1'b0;
    endtask

    initial begin
        int          n;
        int          cnt;
        logic [5:0]  order;
        int          dma_at;
        int          cpu_at;

        for (int i = 0; i < 16; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[4]     = 32'hDEADBEEF;
        ref_mem[4] = 32'hDEADBEEF;

        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = '0; bus.dma_wdata = '0;
        t   = 0;
        pend = '0;
        own_addr = '0;
        own_wdata = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",      bus.busy,      1'b0);
        chk("rst_mem_read",  bus.mem_read,  1'b0);
        chk("rst_mem_write", bus.mem_write, 1'b0);
        chk("rst_cpu_rdata", bus.cpu_rdata, 32'h0);
        chk("rst_dma_done",  bus.dma_done,  1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        t = 0;
        model_reset();

        // Idle with no requests.
        repeat (3) cycle();

        // CPU read of 0x10.
        cpu_access(1'b0, 32'h10, 32'h0);
        chk("t1_rdata", bus.cpu_rdata, 32'hDEADBEEF);

        // CPU write 0x20 then read back.
        cpu_access(1'b1, 32'h20, 32'h12345678);
        chk("t2_rdata_after_write", bus.cpu_rdata, 32'hDEADBEEF);
        cpu_access(1'b0, 32'h20, 32'h0);
        chk("t2_readback", bus.cpu_rdata, 32'h12345678);
        cycle();

        // DMA read while CPU idle; CPU request arrives one cycle later.
        bus.dma_req = 1; bus.dma_we = 0; bus.dma_addr = 32'h10;
        dma_at = -1; cpu_at = -1;
        for (int k = 0; k < 40; k++) begin
            if (k == 1) begin
                bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h20;
            end
            cycle();
            if (obs_ddone === 1'b1) begin dma_at = k; bus.dma_req = 0; end
            if (obs_cdone === 1'b1) begin cpu_at = k; break; end
        end
        bus.cpu_req = 0;
        chk("t4_dma_done_cycle", dma_at, 3);
        chk("t4_cpu_done_cycle", cpu_at, 7);
        chk("t4_dma_rdata", bus.dma_rdata, 32'hDEADBEEF);
        cycle();

        // Contention: both requesting continuously.
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h10;
        bus.dma_req = 1; bus.dma_we = 0; bus.dma_addr = 32'h20;
        order = '0; cnt = 0;
        for (int k = 0; k < 100 && cnt < 6; k++) begin
            cycle();
            if (obs_cdone === 1'b1 || obs_ddone === 1'b1) begin
                order = {order[4:0], obs_ddone};
                cnt++;
            end
        end
        bus.cpu_req = 0; bus.dma_req = 0;
        chk("t3_access_count", cnt, 6);
        chk("t3_grant_order", order, 6'b001001);
        repeat (2) cycle();

        // CPU drops request mid-ACCESS; access still completes.
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h20;
        n = -1;
        for (int k = 0; k < 20; k++) begin
            if (k == 2) bus.cpu_req = 0;
            cycle();
            if (obs_cdone === 1'b1) begin n = k; break; end
        end
        chk("t5_done_cycle", n, 3);
        cycle();

        // Reset during ACCESS cycle 1.
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h10;
        cycle();
        #2;
        rst = 1'b1;
        bus.cpu_req = 0;
        #1;
        chk("t6_busy",      bus.busy,      1'b0);
        chk("t6_mem_read",  bus.mem_read,  1'b0);
        chk("t6_mem_write", bus.mem_write, 1'b0);
        chk("t6_cpu_done",  bus.cpu_done,  1'b0);
        chk("t6_cpu_rdata", bus.cpu_rdata, 32'h0);
        chk("t6_dma_rdata", bus.dma_rdata, 32'h0);
        chk("t6_mem_addr",  bus.mem_addr,  32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        t++;
        model_reset();
        cpu_access(1'b0, 32'h10, 32'h0);
        chk("t6_restart_rdata", bus.cpu_rdata, 32'hDEADBEEF);

        // Randomized traffic from both requesters.
        exp_cdone = 0; exp_ddone = 0;
        for (int k = 0; k < 600; k++) begin
            if (exp_cdone) bus.cpu_req = 0;
            if (exp_ddone) bus.dma_req = 0;
            if (!bus.cpu_req && $urandom_range(0, 2) == 0) begin
                bus.cpu_req   = 1;
                bus.cpu_we    = 1'($urandom_range(0, 1));
                bus.cpu_addr  = {26'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'b00};
                bus.cpu_wdata = $urandom;
            end
            if (!bus.dma_req && $urandom_range(0, 2) == 0) begin
                bus.dma_req   = 1;
                bus.dma_we    = 1'($urandom_range(0, 1));
                bus.dma_addr  = {26'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'b00};
                bus.dma_wdata = $urandom;
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data memory of the pipelined CPU between two requesters: the CPU's MEM stage (port C) and a DMA/program-loader port (port D). It serialises accesses, models a fixed multi-cycle memory latency, and stalls the pipeline while a CPU access is pending. It sits between the MEM-stage pipe register outputs and the Data_Memory instance, and drives the global pipeline stall.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, cycles the memory strobes are held per access (>=1)
- STARVE_MAX, 4, consecutive DMA losses before DMA is forced to win (>=1)

- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- cpu_req_i  in  1  CPU access request (MemRead|MemWrite in MEM stage)
- cpu_we_i  in  1  1 = write, 0 = read
- cpu_addr_i  in  ADDR_W  CPU address
- cpu_wdata_i  in  DATA_W  CPU write data
- cpu_rdata_o  out  DATA_W  CPU read data, valid when cpu_done_o
- cpu_done_o  out  1  one-cycle completion pulse
- cpu_stall_o  out  1  pipeline stall = cpu_req_i & ~cpu_done_o (combinational)
- dma_req_i, dma_we_i, dma_addr_i, dma_wdata_i  in  1/1/ADDR_W/DATA_W  DMA request fields
- dma_rdata_o  out  DATA_W  DMA read data, valid when dma_done_o
- dma_done_o  out  1  one-cycle completion pulse
- mem_addr_o  out  ADDR_W  to Data_Memory addr_i
- mem_wdata_o  out  DATA_W  to Data_Memory data_i
- mem_read_o  out  1  to Data_Memory MemRead_i
- mem_write_o  out  1  to Data_Memory MemWrite_i
- mem_rdata_i  in  DATA_W  from Data_Memory data_o
- busy_o  out  1  state != IDLE

## Operation
- FSM: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE: arbitrate if any req. Grant D if dma_req_i & (~cpu_req_i | starve_cnt == STARVE_MAX); else grant C if cpu_req_i. On grant latch owner, we, addr, wdata; load lat_cnt = MEM_LAT-1; go ACCESS.
- ACCESS: mem_addr_o/mem_wdata_o = latched values; mem_read_o = ~we, mem_write_o = we, held every ACCESS cycle. lat_cnt decrements; when 0, capture mem_rdata_i into owner's rdata register (reads only) and go RESP.
- RESP: owner's done_o = 1 for exactly this cycle; no strobes; no arbitration; go IDLE.
- starve_cnt: in IDLE, +1 (saturating at STARVE_MAX) when both request and C wins; cleared when D granted; unchanged otherwise.
- Requesters hold req and fields stable until their done. Deassertion of req during ACCESS does not abort; access completes and done still pulses.
- Non-owner rdata registers hold previous value; writes never change rdata.

## Timing
- Request seen in IDLE at cycle 0 -> strobes cycles 1..MEM_LAT -> done at cycle MEM_LAT+1 -> IDLE at MEM_LAT+2. Latency MEM_LAT+1; back-to-back throughput one access per MEM_LAT+2 cycles.
- CPU advances on the cycle cpu_done_o=1 (stall low); new request may appear next cycle.
- Simultaneous C and D with starve_cnt < STARVE_MAX: C first; D granted in the next IDLE unless C requests again.
- No request: stays IDLE, all strobes 0.
- Reset (any cycle, including mid-ACCESS): state IDLE, starve_cnt 0, lat_cnt 0, all outputs 0 (rdata registers 0, done 0, strobes 0, busy 0). An interrupted write may or may not have reached memory.
- cpu_stall_o asserts in the same cycle cpu_req_i rises, including when D owns memory.

## Test plan
- Single CPU read, MEM_LAT=2, mem holds 0xDEADBEEF at 0x10: req at cycle 0 -> mem_read_o cycles 1-2 with addr 0x10, cpu_done_o and cpu_rdata_o=0xDEADBEEF at cycle 3, stall high cycles 0-2.
- CPU write 0x12345678 to 0x20 then read 0x20 -> mem_write_o cycles 1-2, done cycle 3; read returns 0x12345678 at cycle 7; cpu_rdata_o unchanged after the write.
- Contention, STARVE_MAX=2, both requesting continuously -> grant order C, C, D, C, C, D; dma_done_o every third access.
- DMA-only read while CPU idle -> dma_done_o at cycle 3, cpu_stall_o stays 0; CPU request arriving cycle 1 -> stall until its done at cycle 7.
- CPU drops req mid-ACCESS -> access finishes, cpu_done_o still pulses at cycle 3.
- rst_i asserted during ACCESS cycle 1 -> immediately all outputs 0, busy_o 0; a request after release restarts with full MEM_LAT+1 latency.
